servo_pwm_multi: RTL and testbench

Multi-channel hobby-servo PWM generator and next-generation servo driver. It derives a 1 µs timebase from the system clock and produces one frame of PERIOD_US microseconds. Each of N_CH outputs carries a pulse whose width in µs is set by a per-channel target register. Targets are range-clamped on write, and the driven position is slew-limited once per frame so that servos move smoothly instead of jumping.

---
 rtl/servo_pkg.sv | 29 ++
 rtl/servo_slew_ch.sv | 67 ++++++
 rtl/servo_pwm_multi.sv | 81 ++++++++
 tb/tb_servo_pwm_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : servo_pkg
// Brief    : Shared width, default constants and target clamp for servo PWM.
// Revision : 1.0
// ============================================================================
package servo_pkg;

  localparam int US_W = 16;

  localparam int c_DEF_CLK_F     = 50;
  localparam int c_DEF_PERIOD_US = 20000;
  localparam int c_DEF_MIN_US    = 500;
  localparam int c_DEF_MAX_US    = 2500;
  localparam int c_DEF_CENTER_US = 1500;
  localparam int c_DEF_STEP_US   = 20;

  function automatic logic [US_W-1:0] clamp_us(
    input logic [US_W-1:0] val,
    input logic [US_W-1:0] lo,
    input logic [US_W-1:0] hi
  );
    if (val < lo)      return lo;
    else if (val > hi) return hi;
    else               return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_slew_ch.sv
`default_nettype none
// ============================================================================
// Module   : servo_slew_ch
// Brief    : One servo channel: target/current registers, per-frame slew,
//            pulse compare flop and busy flag.
// Revision : 1.0
// ============================================================================
module servo_slew_ch
  import servo_pkg::*;
#(
  parameter int CENTER_US = c_DEF_CENTER_US,
  parameter int STEP_US   = c_DEF_STEP_US
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            wr_en,
  input  logic [US_W-1:0] wr_val,
  input  logic            tick,
  input  logic            frame,
  input  logic [US_W-1:0] us_next,
  input  logic            en,
  output logic            pin,
  output logic            busy
);

  localparam logic [US_W-1:0] c_CENTER = US_W'(CENTER_US);
  localparam logic [US_W-1:0] c_STEP   = US_W'(STEP_US);

  logic [US_W-1:0] r_tgt, r_cur;
  logic            r_pin, r_busy;
  logic [US_W-1:0] w_diff, w_slew, w_cur_nxt, w_tgt_nxt;

  // Distance is compared against the step before any add/subtract, so the
  // moved position can never overshoot or wrap.
  always_comb begin
    w_diff = '0;
    w_slew = r_tgt;
    if (r_tgt >= r_cur) begin
      w_diff = r_tgt - r_cur;
      if ((c_STEP != '0) && (w_diff > c_STEP)) w_slew = r_cur + c_STEP;
    end else begin
      w_diff = r_cur - r_tgt;
      if ((c_STEP != '0) && (w_diff > c_STEP)) w_slew = r_cur - c_STEP;
    end
    w_cur_nxt = frame ? w_slew : r_cur;
    w_tgt_nxt = wr_en ? wr_val : r_tgt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tgt  <= c_CENTER;
      r_cur  <= c_CENTER;
      r_pin  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_tgt  <= w_tgt_nxt;
      r_cur  <= w_cur_nxt;
      if (tick) r_pin <= en && (us_next < w_cur_nxt);
      r_busy <= (w_cur_nxt != w_tgt_nxt);
    end
  end

  assign pin  = r_pin;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_multi
// Brief    : Multi-channel slew-limited servo PWM: 1 us timebase, frame
//            counter, write decode and per-channel pulse generators.
// Revision : 1.0
// ============================================================================
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int CLK_F     = c_DEF_CLK_F,
  parameter int N_CH      = 4,
  parameter int PERIOD_US = c_DEF_PERIOD_US,
  parameter int MIN_US    = c_DEF_MIN_US,
  parameter int MAX_US    = c_DEF_MAX_US,
  parameter int CENTER_US = c_DEF_CENTER_US,
  parameter int STEP_US   = c_DEF_STEP_US,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [15:0]     wr_pos,
  input  logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] CTL_PIN,
  output logic            frame_start,
  output logic [N_CH-1:0] busy
);

  localparam int              PS_W    = (CLK_F > 1) ? $clog2(CLK_F) : 1;
  localparam logic [PS_W-1:0] c_PS_TOP = PS_W'(CLK_F - 1);
  localparam logic [US_W-1:0] c_US_TOP = US_W'(PERIOD_US - 1);

  logic [PS_W-1:0] r_pre;
  logic [US_W-1:0] r_us;
  logic            r_fs;
  logic            w_tick, w_frame, w_wr_ok;
  logic [US_W-1:0] w_us_next, w_wr_val;

  assign w_tick    = (r_pre == c_PS_TOP);
  assign w_frame   = w_tick && (r_us == c_US_TOP);
  assign w_us_next = w_frame ? '0 : r_us + 1'b1;
  assign w_wr_ok   = wr_en && (32'(wr_ch) < N_CH);
  assign w_wr_val  = clamp_us(wr_pos, US_W'(MIN_US), US_W'(MAX_US));

  // Counter starts at its last value so the very first tick opens a frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pre <= '0;
      r_us  <= c_US_TOP;
      r_fs  <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_us <= w_us_next;
      r_fs  <= w_frame;
    end
  end

  assign frame_start = r_fs;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_slew_ch #(
      .CENTER_US (CENTER_US),
      .STEP_US   (STEP_US)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (w_wr_ok && (wr_ch == CH_W'(i))),
      .wr_val  (w_wr_val),
      .tick    (w_tick),
      .frame   (w_frame),
      .us_next (w_us_next),
      .en      (ch_en[i]),
      .pin     (CTL_PIN[i]),
      .busy    (busy[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_multi
// Brief    : Directed bench for servo_pwm_multi, unlimited-slew and
//            slew-limited instances side by side, with a per-frame scoreboard.
// Revision : 1.0
// ============================================================================
module tb_servo_pwm_multi;

  localparam int CLK_F     = 2;
  localparam int N_CH      = 5;
  localparam int CH_W      = 3;
  localparam int PERIOD_US = 100;
  localparam int MIN_US    = 10;
  localparam int MAX_US    = 80;
  localparam int CENTER_US = 50;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            wr_en = 1'b0;
  logic [CH_W-1:0] wr_ch = '0;
  logic [15:0]     wr_pos = '0;
  logic [N_CH-1:0] ch_en = '1;
  logic [N_CH-1:0] pin_a, pin_b, busy_a, busy_b;
  logic            fs_a, fs_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  servo_pwm_multi #(.CLK_F(CLK_F), .N_CH(N_CH), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
                    .MAX_US(MAX_US), .CENTER_US(CENTER_US), .STEP_US(0)) dut_a (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos), .ch_en(ch_en),
    .CTL_PIN(pin_a), .frame_start(fs_a), .busy(busy_a));

  servo_pwm_multi #(.CLK_F(CLK_F), .N_CH(N_CH), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
                    .MAX_US(MAX_US), .CENTER_US(CENTER_US), .STEP_US(20)) dut_b (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos), .ch_en(ch_en),
    .CTL_PIN(pin_b), .frame_start(fs_b), .busy(busy_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: index 0 is the unlimited instance, index 1 the limited one.
  int              step_of[2] = '{0, 20};
  int              m_pre, m_us, m_frames, m_v, m_diff;
  int              m_tgt[2][N_CH];
  int              m_cur[2][N_CH];
  int              m_cnt[2][N_CH];
  logic [N_CH-1:0] m_pin[2];
  logic [N_CH-1:0] m_busy[2];
  logic            m_fs, m_tick, m_frame;
  int              q_exp[$];

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      m_pre = 0; m_us = PERIOD_US - 1; m_fs = 1'b0; m_frames = 0;
      q_exp.delete();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N_CH; i++) begin
          m_tgt[d][i] = CENTER_US; m_cur[d][i] = CENTER_US; m_cnt[d][i] = 0;
        end
        m_pin[d] = '0; m_busy[d] = '0;
      end
    end else begin
      m_tick  = (m_pre == CLK_F - 1);
      m_pre   = m_tick ? 0 : m_pre + 1;
      m_frame = m_tick && (m_us == PERIOD_US - 1);
      if (m_tick) m_us = m_frame ? 0 : m_us + 1;
      m_fs = m_frame;
      if (m_frame) begin
        if (m_frames > 0)
          for (int d = 0; d < 2; d++)
            for (int i = 0; i < N_CH; i++) q_exp.push_back(m_cnt[d][i]);
        m_frames++;
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < N_CH; i++) begin
            m_cnt[d][i] = 0;
            m_diff = m_tgt[d][i] - m_cur[d][i];
            if (step_of[d] == 0 || (m_diff <= step_of[d] && -m_diff <= step_of[d]))
              m_cur[d][i] = m_tgt[d][i];
            else
              m_cur[d][i] += (m_diff > 0) ? step_of[d] : -step_of[d];
          end
      end
      if (wr_en && int'(wr_ch) < N_CH) begin
        m_v = int'(wr_pos);
        if (m_v < MIN_US) m_v = MIN_US;
        else if (m_v > MAX_US) m_v = MAX_US;
        for (int d = 0; d < 2; d++) m_tgt[d][wr_ch] = m_v;
      end
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N_CH; i++) begin
          if (m_tick) m_pin[d][i] = ch_en[i] && (m_us < m_cur[d][i]);
          m_busy[d][i] = (m_cur[d][i] != m_tgt[d][i]);
          if (m_pin[d][i]) m_cnt[d][i]++;
        end
    end
  end

  // Monitor: per-cycle check against the model, per-frame widths from the queue.
  int mon_cnt[2][N_CH];
  int meas_last[2][N_CH];
  int mon_frames, q_val;

  initial forever begin
    @(negedge CLK);
    if (RST) begin
      mon_frames = 0;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N_CH; i++) mon_cnt[d][i] = 0;
    end else begin
      chk("cycle_a", {fs_a, busy_a, pin_a}, {m_fs, m_busy[0], m_pin[0]});
      chk("cycle_b", {fs_b, busy_b, pin_b}, {m_fs, m_busy[1], m_pin[1]});
      if (fs_a) begin
        if (mon_frames > 0)
          for (int d = 0; d < 2; d++)
            for (int i = 0; i < N_CH; i++) begin
              if (q_exp.size() == 0) begin
                n_assert++; n_fail++;
                $error("FAIL sb_empty: observed 0 queued expected %0d", N_CH * 2);
              end else begin
                q_val = q_exp.pop_front();
                chk($sformatf("width_d%0d_ch%0d", d, i), mon_cnt[d][i], q_val);
              end
              meas_last[d][i] = mon_cnt[d][i];
            end
        mon_frames++;
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < N_CH; i++) mon_cnt[d][i] = 0;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (pin_a[i]) mon_cnt[0][i]++;
        if (pin_b[i]) mon_cnt[1][i]++;
      end
    end
  end

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!fs_a && n < 400);
    chk(tag, fs_a, 1);
    #1;
  endtask

  task automatic write_ch(input int ch, input int pos);
    wr_ch = CH_W'(ch); wr_pos = 16'(pos); wr_en = 1'b1;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic chk_w(input string tag, input int d, input int ch, input int cycles);
    chk(tag, meas_last[d][ch], cycles);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_pin", {pin_a, pin_b}, 0);
    chk("rst_fs_busy", {fs_a, fs_b, busy_a, busy_b}, 0);

    @(negedge CLK); #2 RST = 1'b0;
    @(negedge CLK); #1 chk("first_tick_early", {fs_a, fs_b}, 2'b00);
    @(negedge CLK); #1 chk("first_tick", {fs_a, fs_b}, 2'b11);
    chk("first_pins", {pin_a, pin_b}, {2 * N_CH{1'b1}});
    wait_fs("fs_f1");
    for (int i = 0; i < N_CH; i++) chk_w("center_w", 0, i, 100);
    chk_w("center_w_b", 1, 4, 100);

    // Clamp
    write_ch(0, 5);
    write_ch(1, 900);
    #1 chk("busy_clamp", {busy_a[1:0], busy_b[1:0]}, 4'b1111);
    wait_fs("fs_f2");
    chk_w("clamp_unaffected", 0, 0, 100);
    wait_fs("fs_f3");
    chk_w("clamp_lo_a", 0, 0, 20);
    chk_w("clamp_hi_a", 0, 1, 160);
    chk_w("slew_lo_b", 1, 0, 60);
    chk_w("slew_hi_b", 1, 1, 140);
    chk("busy_clamp_clr", {busy_a[1:0], busy_b[1:0]}, 4'b0000);
    wait_fs("fs_f4");
    chk_w("slew_lo2_b", 1, 0, 20);
    chk_w("slew_hi2_b", 1, 1, 160);

    // Slew on ch2
    write_ch(2, 10);
    #1 chk("busy_slew_set", {busy_a[2], busy_b[2]}, 2'b11);
    wait_fs("fs_f5");
    chk("busy_slew_b1", {busy_a[2], busy_b[2]}, 2'b01);
    wait_fs("fs_f6");
    chk_w("slew1_a", 0, 2, 20);
    chk_w("slew1_b", 1, 2, 60);
    chk("busy_slew_b2", busy_b[2], 0);
    wait_fs("fs_f7");
    chk_w("slew2_b", 1, 2, 20);

    // Write landing on the frame-boundary cycle, then an out-of-range channel
    repeat (199) @(negedge CLK);
    wr_ch = 3'd3; wr_pos = 16'd70; wr_en = 1'b1;
    @(negedge CLK);
    #1 chk("boundary_fs", fs_a, 1);
    chk("boundary_busy", {busy_a[3], busy_b[3]}, 2'b11);
    wr_ch = 3'd5; wr_pos = 16'd2000;
    @(negedge CLK);
    wr_ch = 3'd7;
    @(negedge CLK);
    wr_en = 1'b0;
    wait_fs("fs_f9");
    chk_w("boundary_keep_a", 0, 3, 100);
    chk_w("boundary_keep_b", 1, 3, 100);
    wait_fs("fs_f10");
    chk_w("boundary_new_a", 0, 3, 140);
    chk_w("boundary_new_b", 1, 3, 140);
    chk_w("bad_ch_ignored", 0, 4, 100);
    chk("bad_ch_busy", {busy_a, busy_b}, 0);

    // Enable gating
    repeat (20) @(negedge CLK);
    ch_en[1] = 1'b0;
    repeat (2) @(negedge CLK);
    #1 chk("en_off_pin", {pin_a[1], pin_b[1]}, 2'b00);
    chk("en_off_others", {pin_a[4], pin_a[3], pin_b[4], pin_b[3]}, 4'b1111);
    wait_fs("fs_f11");
    wait_fs("fs_f12");
    chk_w("en_off_w_a", 0, 1, 0);
    chk_w("en_off_w_b", 1, 1, 0);
    chk_w("en_off_other_w", 0, 4, 100);
    repeat (20) @(negedge CLK);
    ch_en[1] = 1'b1;
    repeat (2) @(negedge CLK);
    #1 chk("en_on_pin", {pin_a[1], pin_b[1]}, 2'b11);

    // Asynchronous reset mid-frame
    repeat (10) @(negedge CLK);
    #2 RST = 1'b1;
    #1 chk("async_rst_pin", {pin_a, pin_b}, 0);
    chk("async_rst_fs_busy", {fs_a, fs_b, busy_a, busy_b}, 0);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK); #1 chk("re_tick_early", {fs_a, fs_b}, 2'b00);
    @(negedge CLK); #1 chk("re_tick", {fs_a, fs_b}, 2'b11);
    wait_fs("fs_re1");
    for (int i = 0; i < N_CH; i++) begin
      chk_w("re_center_a", 0, i, 100);
      chk_w("re_center_b", 1, i, 100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
